// File: rtl/mc_control_fsm_pkg.sv
// mc_pkg: shared types and encodings for the multicycle control sequencer.
//   state_e         sequencer states
//   instr_class_e   decoded instruction class
//   ctrl_t          Moore control word produced by each state
//   state_ctrl()    state -> control word decode
package mc_pkg;

   typedef enum logic [3:0] {
      StIdle, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
      StExec, StAluWb, StBranch, StAddiEx, StAddiWb, StJump
   } state_e;

   typedef enum logic [2:0] {ClsR, ClsLw, ClsSw, ClsBeq, ClsAddi, ClsJ} instr_class_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

   // FETCH's ir_write/pc_write are qualified by mem_ready outside this decode.
   function automatic ctrl_t state_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         StFetch: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
         end
         StDecode: c.alu_src_b = SRCB_IMM_SH;
         StMemAdr, StAddiEx: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         StMemRd: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         StMemWb: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         StMemWr: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         StExec: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALUOP_FUNCT;
         end
         StAluWb: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         StBranch: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = ALUOP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
         end
         StAddiWb: c.reg_write = 1'b1;
         StJump: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: opcode/mem_ready inputs and datapath control outputs of the sequencer.
//   master: the sequencer (drives controls)   slave: datapath / memory / register file
interface mc_control_fsm_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic [1:0] pc_source;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       illegal_op;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op
   );
endinterface

// File: rtl/mc_control_fsm_opcode_decode.sv
// mc_opcode_decode: combinational opcode -> instruction class and illegal flag.
//   opcode_i   IR[31:26]
//   cls_o      instruction class (don't care when illegal_o)
//   illegal_o  opcode is not one of R, lw, sw, beq, addi, j
module mc_opcode_decode
   import mc_pkg::*;
(
   input  logic [5:0]   opcode_i,
   output instr_class_e cls_o,
   output logic         illegal_o
);

   always_comb begin
      cls_o     = ClsR;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: cls_o = ClsR;
         OP_LW:    cls_o = ClsLw;
         OP_SW:    cls_o = ClsSw;
         OP_BEQ:   cls_o = ClsBeq;
         OP_ADDI:  cls_o = ClsAddi;
         OP_J:     cls_o = ClsJ;
         default:  illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control sequencer (FETCH -> DECODE -> class-specific steps).
//   clk, rst_n   clock and synchronous active-low reset
//   bus          mc_control_fsm_if.master: opcode/mem_ready in, datapath controls out
//   instr_count  retired-instruction count, CNT_W bits
// Build option: define MC_RETIRE_CNT_EN to build the retire counter; otherwise instr_count is 0.
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mc_control_fsm_if.master      bus,
   output logic [CNT_W-1:0]      instr_count
);

   state_e       state_q, state_d;
   ctrl_t        ctrl_q;
   instr_class_e cls;
   logic         illegal;
   logic         fetch_go;

   mc_opcode_decode u_decode (
      .opcode_i  (bus.opcode),
      .cls_o     (cls),
      .illegal_o (illegal)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   state_d = StFetch;
         StFetch:  if (bus.mem_ready) state_d = StDecode;
         StDecode: begin
            if (illegal) begin
               state_d = StFetch;
            end else begin
               case (cls)
                  ClsR:         state_d = StExec;
                  ClsLw, ClsSw: state_d = StMemAdr;
                  ClsBeq:       state_d = StBranch;
                  ClsAddi:      state_d = StAddiEx;
                  ClsJ:         state_d = StJump;
                  default:      state_d = StFetch;
               endcase
            end
         end
         // IR still holds the lw/sw opcode here.
         StMemAdr: state_d = (cls == ClsSw) ? StMemWr : StMemRd;
         StMemRd:  if (bus.mem_ready) state_d = StMemWb;
         StMemWr:  if (bus.mem_ready) state_d = StFetch;
         StExec:   state_d = StAluWb;
         StAddiEx: state_d = StAddiWb;
         StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
         default:  state_d = StIdle;
      endcase
   end

   // Control word registered from the next state, so ctrl_q always matches state_q.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d);
      end
   end

   assign fetch_go = (state_q == StFetch) && bus.mem_ready;

   assign bus.pc_write      = ctrl_q.pc_write | fetch_go;
   assign bus.ir_write      = fetch_go;
   assign bus.pc_write_cond = ctrl_q.pc_write_cond;
   assign bus.pc_source     = ctrl_q.pc_source;
   assign bus.i_or_d        = ctrl_q.i_or_d;
   assign bus.mem_read      = ctrl_q.mem_read;
   assign bus.mem_write     = ctrl_q.mem_write;
   assign bus.reg_dst       = ctrl_q.reg_dst;
   assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
   assign bus.reg_write     = ctrl_q.reg_write;
   assign bus.alu_src_a     = ctrl_q.alu_src_a;
   assign bus.alu_src_b     = ctrl_q.alu_src_b;
   assign bus.alu_op        = ctrl_q.alu_op;
   assign bus.illegal_op    = (state_q == StDecode) && illegal;

`ifdef MC_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   always_comb begin
      retire = 1'b0;
      case (state_q)
         StMemWb, StAluWb, StAddiWb, StBranch, StJump: retire = 1'b1;
         StMemWr:                                      retire = bus.mem_ready;
         default:                                      retire = 1'b0;
      endcase
      cnt_d = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign instr_count = cnt_q;
`else
   assign instr_count = '0;
`endif

endmodule
